// File: rtl/cv32e40p_if_id_voter_ft.sv
// ID-side majority voter for the triplicated IF/ID bundle.
// Tracks per-lane mismatches and degrades voting around lanes declared faulty.
//
// state      | meaning
// ST_OK      | lane agrees with the voted bundle on its last consumed sample
// ST_SUSPECT | lane mismatched cnt consecutive consumed samples (cnt < PERM_THRESH)
// ST_FAULTY  | lane excluded from voting until err_clear_i or reset
module cv32e40p_if_id_voter_ft #(
  parameter int unsigned FT_EN       = 1,
  parameter int unsigned PERM_THRESH = 4,
  parameter int unsigned ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           instr_valid_id_i,
  input  logic [2:0][31:0]     instr_rdata_id_i,
  input  logic [2:0]           is_compressed_id_i,
  input  logic [2:0]           illegal_c_insn_id_i,
  input  logic [2:0][31:0]     pc_id_i,
  input  logic [2:0]           is_fetch_failed_i,
  input  logic                 sample_i,
  input  logic                 err_clear_i,
  output logic                 instr_valid_o,
  output logic [31:0]          instr_rdata_o,
  output logic                 is_compressed_o,
  output logic                 illegal_c_insn_o,
  output logic [31:0]          pc_o,
  output logic                 is_fetch_failed_o,
  output logic                 err_detected_o,
  output logic                 err_uncorrectable_o,
  output logic [2:0]           lane_fault_o,
  output logic [ERR_CNT_W-1:0] err_count_o
);

  localparam int unsigned BW = 68;

  logic [2:0][BW-1:0] lane;
  logic [BW-1:0]      voted;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      lane[i] = {instr_valid_id_i[i], instr_rdata_id_i[i], is_compressed_id_i[i],
                 illegal_c_insn_id_i[i], pc_id_i[i], is_fetch_failed_i[i]};
    end
  end

  assign {instr_valid_o, instr_rdata_o, is_compressed_o,
          illegal_c_insn_o, pc_o, is_fetch_failed_o} = voted;

  generate
    if (FT_EN == 0) begin : g_bypass
      assign voted               = lane[0];
      assign err_detected_o      = 1'b0;
      assign err_uncorrectable_o = 1'b0;
      assign lane_fault_o        = 3'b000;
      assign err_count_o         = '0;
    end else begin : g_ft
      typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_FAULTY  = 2'd2
      } lane_state_e;

      localparam logic [4:0] THRESH = 5'(PERM_THRESH);

      lane_state_e          state_q [3];
      lane_state_e          state_d [3];
      logic [3:0]           cnt_q   [3];
      logic [3:0]           cnt_d   [3];
      logic [4:0]           cnt_inc [3];
      logic [2:0]           fault;
      logic [2:0]           healthy;
      logic [2:0]           mm;
      logic [BW-1:0]        maj;
      logic                 d01, d02, d12;
      logic                 det, unc;
      logic [ERR_CNT_W-1:0] err_cnt_q;

      always_comb begin
        for (int i = 0; i < 3; i++) begin
          fault[i] = (state_q[i] == ST_FAULTY);
        end
      end

      assign healthy = ~fault;
      assign maj     = (lane[0] & lane[1]) | (lane[0] & lane[2]) | (lane[1] & lane[2]);
      assign d01     = (lane[0] != lane[1]);
      assign d02     = (lane[0] != lane[2]);
      assign d12     = (lane[1] != lane[2]);

      // Degraded voting: with two healthy lanes there is no majority, so any
      // disagreement is uncorrectable and both lanes are blamed.
      always_comb begin
        voted = lane[0];
        det   = 1'b0;
        unc   = 1'b0;
        mm    = 3'b000;
        case (healthy)
          3'b111: begin
            voted = maj;
            unc   = d01 & d02 & d12;
            for (int i = 0; i < 3; i++) begin
              mm[i] = (lane[i] != maj);
            end
            det = |mm;
          end
          3'b011: begin
            voted = lane[0];
            if (d01) begin
              mm = 3'b011; det = 1'b1; unc = 1'b1;
            end
          end
          3'b101: begin
            voted = lane[0];
            if (d02) begin
              mm = 3'b101; det = 1'b1; unc = 1'b1;
            end
          end
          3'b110: begin
            voted = lane[1];
            if (d12) begin
              mm = 3'b110; det = 1'b1; unc = 1'b1;
            end
          end
          3'b001: voted = lane[0];
          3'b010: voted = lane[1];
          3'b100: voted = lane[2];
          default: begin
            voted = lane[0];
            unc   = 1'b1;
          end
        endcase
      end

      always_comb begin
        for (int i = 0; i < 3; i++) begin
          state_d[i] = state_q[i];
          cnt_d[i]   = cnt_q[i];
          cnt_inc[i] = {1'b0, cnt_q[i]} + 5'd1;
          if (err_clear_i) begin
            state_d[i] = ST_OK;
            cnt_d[i]   = 4'd0;
          end else if (sample_i) begin
            case (state_q[i])
              ST_OK: begin
                if (mm[i]) begin
                  cnt_d[i]   = 4'd1;
                  state_d[i] = (THRESH <= 5'd1) ? ST_FAULTY : ST_SUSPECT;
                end
              end
              ST_SUSPECT: begin
                if (mm[i]) begin
                  cnt_d[i] = cnt_inc[i][3:0];
                  if (cnt_inc[i] >= THRESH) begin
                    state_d[i] = ST_FAULTY;
                  end
                end else begin
                  state_d[i] = ST_OK;
                  cnt_d[i]   = 4'd0;
                end
              end
              ST_FAULTY: state_d[i] = ST_FAULTY;
              default: begin
                state_d[i] = ST_OK;
                cnt_d[i]   = 4'd0;
              end
            endcase
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < 3; i++) begin
            state_q[i] <= ST_OK;
            cnt_q[i]   <= 4'd0;
          end
        end else begin
          for (int i = 0; i < 3; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          err_cnt_q <= '0;
        end else if (err_clear_i) begin
          err_cnt_q <= '0;
        end else if (sample_i && det && !unc && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
          err_cnt_q <= err_cnt_q + 1'b1;
        end
      end

      assign err_detected_o      = det;
      assign err_uncorrectable_o = unc;
      assign lane_fault_o        = fault;
      assign err_count_o         = err_cnt_q;
    end
  endgenerate

endmodule

// File: tb/tb_cv32e40p_if_id_voter_ft.sv
// Randomized and directed checks of the IF/ID voter against a per-bit
// counting reference model; a second instance exercises counter saturation.
module tb_cv32e40p_if_id_voter_ft;

  localparam int THRESH = 4;

  logic             clk;
  logic             rst_n;
  logic [2:0]       instr_valid_id_i;
  logic [2:0][31:0] instr_rdata_id_i;
  logic [2:0]       is_compressed_id_i;
  logic [2:0]       illegal_c_insn_id_i;
  logic [2:0][31:0] pc_id_i;
  logic [2:0]       is_fetch_failed_i;
  logic             sample_i;
  logic             err_clear_i;
  logic             instr_valid_o, is_compressed_o, illegal_c_insn_o, is_fetch_failed_o;
  logic [31:0]      instr_rdata_o, pc_o;
  logic             err_detected_o, err_uncorrectable_o;
  logic [2:0]       lane_fault_o;
  logic [15:0]      err_count_o;
  logic             s_valid, s_comp, s_ill, s_ff, s_det, s_unc;
  logic [31:0]      s_rdata, s_pc;
  logic [2:0]       s_fault;
  logic [1:0]       s_count;

  cv32e40p_if_id_voter_ft dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid_id_i(instr_valid_id_i), .instr_rdata_id_i(instr_rdata_id_i),
    .is_compressed_id_i(is_compressed_id_i), .illegal_c_insn_id_i(illegal_c_insn_id_i),
    .pc_id_i(pc_id_i), .is_fetch_failed_i(is_fetch_failed_i),
    .sample_i(sample_i), .err_clear_i(err_clear_i),
    .instr_valid_o(instr_valid_o), .instr_rdata_o(instr_rdata_o),
    .is_compressed_o(is_compressed_o), .illegal_c_insn_o(illegal_c_insn_o),
    .pc_o(pc_o), .is_fetch_failed_o(is_fetch_failed_o),
    .err_detected_o(err_detected_o), .err_uncorrectable_o(err_uncorrectable_o),
    .lane_fault_o(lane_fault_o), .err_count_o(err_count_o)
  );

  cv32e40p_if_id_voter_ft #(.ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .instr_valid_id_i(instr_valid_id_i), .instr_rdata_id_i(instr_rdata_id_i),
    .is_compressed_id_i(is_compressed_id_i), .illegal_c_insn_id_i(illegal_c_insn_id_i),
    .pc_id_i(pc_id_i), .is_fetch_failed_i(is_fetch_failed_i),
    .sample_i(sample_i), .err_clear_i(err_clear_i),
    .instr_valid_o(s_valid), .instr_rdata_o(s_rdata),
    .is_compressed_o(s_comp), .illegal_c_insn_o(s_ill),
    .pc_o(s_pc), .is_fetch_failed_o(s_ff),
    .err_detected_o(s_det), .err_uncorrectable_o(s_unc),
    .lane_fault_o(s_fault), .err_count_o(s_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  logic [67:0] b [3];
  int          streak [3];
  bit          faulty [3];
  int          cnt_main, cnt_sat;
  logic [67:0] m_voted;
  bit          m_det, m_unc;
  bit          m_mm [3];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      streak[i] = 0;
      faulty[i] = 0;
    end
    cnt_main = 0;
    cnt_sat  = 0;
  endtask

  task automatic model_eval();
    int h [$];
    int ones;
    h = {};
    for (int i = 0; i < 3; i++) begin
      m_mm[i] = 0;
      if (!faulty[i]) h.push_back(i);
    end
    m_det = 0;
    m_unc = 0;
    m_voted = b[0];
    if (h.size() == 3) begin
      for (int k = 0; k < 68; k++) begin
        ones = int'(b[0][k]) + int'(b[1][k]) + int'(b[2][k]);
        m_voted[k] = (ones >= 2);
      end
      m_unc = (b[0] != b[1]) && (b[0] != b[2]) && (b[1] != b[2]);
      for (int i = 0; i < 3; i++) begin
        m_mm[i] = (b[i] != m_voted);
        if (m_mm[i]) m_det = 1;
      end
    end else if (h.size() == 2) begin
      m_voted = b[h[0]];
      if (b[h[0]] != b[h[1]]) begin
        m_det = 1;
        m_unc = 1;
        m_mm[h[0]] = 1;
        m_mm[h[1]] = 1;
      end
    end else if (h.size() == 1) begin
      m_voted = b[h[0]];
    end else begin
      m_unc = 1;
    end
  endtask

  task automatic model_update(input bit smp, input bit clr);
    if (clr) begin
      model_reset();
    end else if (smp) begin
      for (int i = 0; i < 3; i++) begin
        if (!faulty[i]) begin
          if (m_mm[i]) begin
            streak[i]++;
            if (streak[i] >= THRESH) faulty[i] = 1;
          end else begin
            streak[i] = 0;
          end
        end
      end
      if (m_det && !m_unc) begin
        if (cnt_main < 65535) cnt_main++;
        if (cnt_sat < 3) cnt_sat++;
      end
    end
  endtask

  // One cycle: drive at negedge, check combinational and state outputs, then
  // advance the model by what the coming posedge will do.
  task automatic step(input logic [67:0] l0, input logic [67:0] l1, input logic [67:0] l2,
                      input bit smp, input bit clr, input bit rst_v);
    @(negedge clk);
    b[0] = l0; b[1] = l1; b[2] = l2;
    for (int i = 0; i < 3; i++) begin
      {instr_valid_id_i[i], instr_rdata_id_i[i], is_compressed_id_i[i],
       illegal_c_insn_id_i[i], pc_id_i[i], is_fetch_failed_i[i]} = b[i];
    end
    sample_i    = smp;
    err_clear_i = clr;
    rst_n       = rst_v;
    if (!rst_v) model_reset();
    #1;
    model_eval();
    chk("voted", {instr_valid_o, instr_rdata_o, is_compressed_o, illegal_c_insn_o,
                  pc_o, is_fetch_failed_o}, m_voted);
    chk("err_detected", 68'(err_detected_o), 68'(m_det));
    chk("err_uncorrectable", 68'(err_uncorrectable_o), 68'(m_unc));
    chk("lane_fault", 68'(lane_fault_o), 68'({faulty[2], faulty[1], faulty[0]}));
    chk("err_count", 68'(err_count_o), 68'(cnt_main));
    chk("err_count_sat", 68'(s_count), 68'(cnt_sat));
    chk("sat_lane_fault", 68'(s_fault), 68'({faulty[2], faulty[1], faulty[0]}));
    if (rst_v) model_update(smp, clr);
  endtask

  function automatic logic [67:0] mk(input logic [31:0] rdata, input logic [31:0] pc);
    return {1'b1, rdata, 1'b0, 1'b0, pc, 1'b0};
  endfunction

  logic [67:0] clean, seu, pcbad, bad0, t1, t2, t4, base;
  logic [67:0] x [3];
  logic [95:0] r;
  logic [67:0] stuck_mask;
  int          stuck_lane, stuck_left;

  initial begin
    rst_n = 1'b0;
    sample_i = 1'b0;
    err_clear_i = 1'b0;
    instr_valid_id_i = '0;
    instr_rdata_id_i = '0;
    is_compressed_id_i = '0;
    illegal_c_insn_id_i = '0;
    pc_id_i = '0;
    is_fetch_failed_i = '0;
    model_reset();

    clean = mk(32'h00A00093, 32'h80);
    seu   = mk(32'h00A00093 ^ 32'h20, 32'h80);
    pcbad = mk(32'h00A00093, 32'h84);
    bad0  = mk(32'h00A00093 ^ 32'h100, 32'h80);
    t1    = mk(32'h1, 32'h80);
    t2    = mk(32'h2, 32'h80);
    t4    = mk(32'h4, 32'h80);

    step('0, '0, '0, 0, 0, 0);
    step('0, '0, '0, 0, 0, 0);
    chk("reset_count", 68'(err_count_o), 68'd0);

    for (int i = 0; i < 10; i++) step(clean, clean, clean, 1, 0, 1);
    chk("clean_count", 68'(err_count_o), 68'd0);

    step(clean, seu, clean, 1, 0, 1);
    chk("seu_rdata", 68'(instr_rdata_o), 68'h00A00093);
    chk("seu_detected", 68'(err_detected_o), 68'd1);
    step(clean, clean, clean, 1, 0, 1);
    chk("seu_count", 68'(err_count_o), 68'd1);

    for (int i = 0; i < 4; i++) step(clean, clean, pcbad, 1, 0, 1);
    step(clean, clean, clean, 0, 0, 1);
    chk("perm_fault", 68'(lane_fault_o), 68'b100);
    step(clean, seu, clean, 0, 0, 1);
    chk("perm_uncorr", 68'(err_uncorrectable_o), 68'd1);

    step(clean, clean, clean, 1, 1, 1);
    step(clean, clean, clean, 0, 0, 1);
    chk("clear_fault", 68'(lane_fault_o), 68'd0);

    for (int i = 0; i < 20; i++) step(bad0, clean, clean, 0, 0, 1);
    step(bad0, clean, clean, 1, 0, 1);
    step(clean, clean, clean, 0, 0, 1);
    chk("hold_count", 68'(err_count_o), 68'd1);
    for (int i = 0; i < 3; i++) step(bad0, clean, clean, 1, 0, 1);
    step(clean, clean, clean, 0, 0, 1);
    chk("hold_then_fault", 68'(lane_fault_o), 68'b001);
    step(clean, clean, clean, 1, 1, 1);

    step(t1, t2, t4, 1, 0, 1);
    chk("triple_uncorr", 68'(err_uncorrectable_o), 68'd1);
    chk("triple_rdata", 68'(instr_rdata_o), 68'd0);
    step(clean, clean, clean, 0, 0, 1);
    chk("triple_count", 68'(err_count_o), 68'd0);

    for (int i = 0; i < 5; i++) step(clean, seu, (i % 2) ? clean : seu ^ seu ^ clean, 1, 0, 1);
    step(clean, clean, clean, 0, 0, 1);
    chk("sat_count", 68'(s_count), 68'd3);
    step(clean, seu, clean, 1, 1, 1);
    step(clean, clean, clean, 0, 0, 1);
    chk("clear_count", 68'(err_count_o), 68'd0);

    step(clean, clean, pcbad, 1, 0, 1);
    step(clean, clean, clean, 0, 0, 0);
    chk("rst_count", 68'(err_count_o), 68'd0);
    step(clean, clean, clean, 0, 0, 1);

    stuck_left = 0;
    stuck_lane = 0;
    stuck_mask = '0;
    for (int n = 0; n < 3000; n++) begin
      r = {$urandom(), $urandom(), $urandom()};
      base = r[67:0];
      if ($urandom_range(3, 0) == 0) base = clean;
      for (int i = 0; i < 3; i++) begin
        x[i] = base;
        if ($urandom_range(7, 0) == 0) x[i] = x[i] ^ (68'd1 << $urandom_range(67, 0));
      end
      if (stuck_left == 0 && $urandom_range(39, 0) == 0) begin
        stuck_left = $urandom_range(10, 3);
        stuck_lane = $urandom_range(2, 0);
        stuck_mask = 68'd1 << $urandom_range(67, 0);
      end
      if (stuck_left > 0) begin
        x[stuck_lane] = x[stuck_lane] ^ stuck_mask;
        stuck_left--;
      end
      step(x[0], x[1], x[2], $urandom_range(3, 0) != 0, $urandom_range(199, 0) == 0,
           $urandom_range(499, 0) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
